xadc_drp_responder: RTL and testbench

- Synthesizable XADC stand-in that implements the responder end of the DRP read interface and the conversion-status outputs.
- Lets the joystick/ADC reader path run in simulation and on boards with no analog front end.
- Sequences four aux channels, publishes programmable 12-bit samples as left-aligned 16-bit result registers, and emits eoc/eos/busy/channel.
- Answers DRP reads with drdy after a fixed latency.

---
 rtl/xadc_drp_responder.sv | 277 +++++++++++++++++++++++++++
 tb/tb_xadc_drp_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xadc_drp_responder.sv
// ---------------------------------------------------------------------------
// xadc_drp_responder
//
// Synthesizable stand-in for the XADC: it sequences four aux channels,
// publishes programmable 12-bit samples as left-aligned 16-bit result
// registers, drives the conversion status outputs and answers DRP accesses
// with drdy after a fixed latency.
//
// Optional feature macro: XADC_DRP_AVG_EN
//   undefined : each result register holds the last captured sample
//   defined   : each result register holds the truncated mean of the last
//               four samples captured for that channel (history resets to 0)
//
// Parameters:
//   CONV_CYCLES  busy cycles per conversion (>=2); period is CONV_CYCLES+1
//   DRDY_LAT     cycles from an accepted den to drdy_out (>=1)
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high
//   sample0..3   values converted for vaux3/vaux10/vaux2/vaux11
//                (addresses 0x13/0x1A/0x12/0x1B)
//   den_in       DRP enable
//   dwe_in       DRP write enable (writes complete but change nothing)
//   daddr_in     DRP address
//   di_in        DRP write data (ignored)
//   drdy_out     one-cycle DRP completion pulse
//   do_out       DRP read data, held until the next drdy
//   channel_out  channel of the last completed conversion
//   eoc_out      one-cycle end-of-conversion pulse
//   eos_out      one-cycle end-of-sequence pulse (after channel 0x1B)
//   busy_out     conversion in progress
// ---------------------------------------------------------------------------
module xadc_drp_responder #(
    parameter int unsigned CONV_CYCLES = 26,
    parameter int unsigned DRDY_LAT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] sample0,
    input  logic [11:0] sample1,
    input  logic [11:0] sample2,
    input  logic [11:0] sample3,
    input  logic        den_in,
    input  logic        dwe_in,
    input  logic [6:0]  daddr_in,
    input  logic [15:0] di_in,
    output logic        drdy_out,
    output logic [15:0] do_out,
    output logic [4:0]  channel_out,
    output logic        eoc_out,
    output logic        eos_out,
    output logic        busy_out
);

    localparam int unsigned CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam int unsigned RW = $clog2(DRDY_LAT + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(CONV_CYCLES - 1);
    localparam logic [RW-1:0] LAT_INIT = RW'(DRDY_LAT - 1);
    localparam logic [RW-1:0] LAT_ONE  = RW'(1);

    typedef enum logic {
        S_CONV,
        S_DONE
    } state_t;

    // Conversion sequencer state
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [1:0]      idx_q,   idx_d;
    logic [4:0]      chan_q,  chan_d;
    logic [15:0]     res_q [4];
    logic [15:0]     res_d [4];

    // DRP transaction state
    logic            pend_q,  pend_d;
    logic [RW-1:0]   rcnt_q,  rcnt_d;
    logic [15:0]     snap_q,  snap_d;
    logic            drdy_q,  drdy_d;
    logic [15:0]     do_q,    do_d;

    logic [11:0]     cur_sample;
    logic [15:0]     new_result;
    logic [15:0]     rd_data;
    logic            accept;

    // Write data is never stored.
    logic            unused_di;
    assign unused_di = ^di_in;

    function automatic logic [4:0] chan_addr(input logic [1:0] idx);
        logic [4:0] a;
        case (idx)
            2'd0:    a = 5'h13;
            2'd1:    a = 5'h1A;
            2'd2:    a = 5'h12;
            default: a = 5'h1B;
        endcase
        return a;
    endfunction

    always_comb begin
        case (idx_q)
            2'd0:    cur_sample = sample0;
            2'd1:    cur_sample = sample1;
            2'd2:    cur_sample = sample2;
            default: cur_sample = sample3;
        endcase
    end

`ifdef XADC_DRP_AVG_EN
    // Only the three previous samples are stored; the fourth is the sample
    // being captured right now.
    logic [11:0] hist_q [4][3];
    logic [11:0] hist_d [4][3];
    logic [13:0] sum4;
    logic        capture;

    always_comb begin
        sum4 = {2'b00, cur_sample}
             + {2'b00, hist_q[idx_q][0]}
             + {2'b00, hist_q[idx_q][1]}
             + {2'b00, hist_q[idx_q][2]};
        new_result = {sum4[13:2], 4'h0};
    end

    always_comb begin
        hist_d = hist_q;
        if (capture) begin
            hist_d[idx_q][2] = hist_q[idx_q][1];
            hist_d[idx_q][1] = hist_q[idx_q][0];
            hist_d[idx_q][0] = cur_sample;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned c = 0; c < 4; c++) begin
                for (int unsigned k = 0; k < 3; k++) begin
                    hist_q[c][k] <= '0;
                end
            end
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    always_comb begin
        new_result = {cur_sample, 4'h0};
    end
`endif

    // Conversion FSM: next state, capture and status outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        chan_d  = chan_q;
        res_d   = res_q;
`ifdef XADC_DRP_AVG_EN
        capture = 1'b0;
`endif
        case (state_q)
            S_CONV: begin
                if (cnt_q == CNT_LAST) begin
                    state_d       = S_DONE;
                    chan_d        = chan_addr(idx_q);
                    res_d[idx_q]  = new_result;
`ifdef XADC_DRP_AVG_EN
                    capture       = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_CONV;
                cnt_d   = '0;
                idx_d   = idx_q + 2'd1;
            end
            default: begin
                state_d = S_CONV;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_CONV;
            cnt_q   <= '0;
            idx_q   <= '0;
            chan_q  <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            chan_q  <= chan_d;
            res_q   <= res_d;
        end
    end

    // DRP address map, evaluated on the registers as they stand in the den
    // cycle, so a capture on the same edge is not visible to this access.
    always_comb begin
        rd_data = '0;
        if (!dwe_in) begin
            case (daddr_in)
                7'h13:   rd_data = res_q[0];
                7'h1A:   rd_data = res_q[1];
                7'h12:   rd_data = res_q[2];
                7'h1B:   rd_data = res_q[3];
                default: rd_data = '0;
            endcase
        end
    end

    // pend_q drops on the edge that raises drdy, so a den in the drdy cycle
    // is accepted as a fresh transaction.
    assign accept = den_in & ~pend_q;

    always_comb begin
        pend_d = pend_q;
        rcnt_d = rcnt_q;
        snap_d = snap_q;
        drdy_d = 1'b0;
        do_d   = do_q;
        if (pend_q) begin
            if (rcnt_q == LAT_ONE) begin
                drdy_d = 1'b1;
                do_d   = snap_q;
                pend_d = 1'b0;
            end else begin
                rcnt_d = rcnt_q - 1'b1;
            end
        end
        if (accept) begin
            if (DRDY_LAT == 1) begin
                drdy_d = 1'b1;
                do_d   = rd_data;
            end else begin
                pend_d = 1'b1;
                rcnt_d = LAT_INIT;
                snap_d = rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= 1'b0;
            rcnt_q <= '0;
            snap_q <= '0;
            drdy_q <= 1'b0;
            do_q   <= '0;
        end else begin
            pend_q <= pend_d;
            rcnt_q <= rcnt_d;
            snap_q <= snap_d;
            drdy_q <= drdy_d;
            do_q   <= do_d;
        end
    end

    // busy is gated by reset so every output reads 0 while reset is held.
    assign busy_out    = (state_q == S_CONV) & ~reset;
    assign eoc_out     = (state_q == S_DONE);
    assign eos_out     = (state_q == S_DONE) && (idx_q == 2'd3);
    assign channel_out = chan_q;
    assign drdy_out    = drdy_q;
    assign do_out      = do_q;

endmodule

// File: tb/tb_xadc_drp_responder.sv
module tb_xadc_drp_responder;

    localparam int unsigned CC  = 4;
    localparam int unsigned LAT = 2;
    localparam int          P   = CC + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] s0 = '0, s1 = '0, s2 = '0, s3 = '0;
    logic        den = 1'b0, dwe = 1'b0;
    logic [6:0]  daddr = '0;
    logic [15:0] di = '0;
    logic        drdy_out;
    logic [15:0] do_out;
    logic [4:0]  channel_out;
    logic        eoc_out, eos_out, busy_out;

    always #5 clk = ~clk;

    xadc_drp_responder #(.CONV_CYCLES(CC), .DRDY_LAT(LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .sample0     (s0),
        .sample1     (s1),
        .sample2     (s2),
        .sample3     (s3),
        .den_in      (den),
        .dwe_in      (dwe),
        .daddr_in    (daddr),
        .di_in       (di),
        .drdy_out    (drdy_out),
        .do_out      (do_out),
        .channel_out (channel_out),
        .eoc_out     (eoc_out),
        .eos_out     (eos_out),
        .busy_out    (busy_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: everything derives from the cycle number since reset
    // release plus the last value captured for each channel.
    int          m_cyc;
    logic [15:0] m_res [4];
    logic [11:0] m_hist [4][$];
    int          m_drdy_at;
    logic [15:0] m_drdy_data;
    logic [15:0] m_do;
    logic [11:0] stage [4];
    logic [15:0] drdy_log [$];
    logic        obs_eoc;
    logic [4:0]  obs_chan;

    function automatic logic [4:0] chan_addr(input int i);
        logic [4:0] tbl [4];
        tbl[0] = 5'h13; tbl[1] = 5'h1A; tbl[2] = 5'h12; tbl[3] = 5'h1B;
        return tbl[i % 4];
    endfunction

    function automatic logic [15:0] mapped(input logic [6:0] a);
        case (a)
            7'h13:   return m_res[0];
            7'h1A:   return m_res[1];
            7'h12:   return m_res[2];
            7'h1B:   return m_res[3];
            default: return 16'h0000;
        endcase
    endfunction

    function automatic bit exp_eoc();
        return (m_cyc % P) == CC;
    endfunction

    function automatic logic [4:0] exp_chan();
        if (m_cyc < CC) return 5'h00;
        return chan_addr((m_cyc - CC) / P);
    endfunction

    task automatic model_reset();
        m_cyc     = 0;
        m_drdy_at = -1;
        m_drdy_data = '0;
        m_do      = '0;
        for (int i = 0; i < 4; i++) begin
            m_res[i] = '0;
            m_hist[i] = '{12'h0, 12'h0, 12'h0, 12'h0};
        end
    endtask

    task automatic model_capture(input int idx, input logic [11:0] smp);
`ifdef XADC_DRP_AVG_EN
        int sum;
        m_hist[idx].push_back(smp);
        void'(m_hist[idx].pop_front());
        sum = 0;
        foreach (m_hist[idx][k]) sum += int'(m_hist[idx][k]);
        m_res[idx] = 16'((sum / 4) * 16);
`else
        m_res[idx] = {smp, 4'h0};
`endif
    endtask

    task automatic run_cycle(input logic rs, input logic d_en, input logic d_we,
                             input logic [6:0] a, input logic [15:0] wdata);
        bit          e_eoc, e_drdy;
        @(posedge clk);
        #1;
        reset = rs; den = d_en; dwe = d_we; daddr = a; di = wdata;
        s0 = stage[0]; s1 = stage[1]; s2 = stage[2]; s3 = stage[3];
        @(negedge clk);
        e_eoc  = exp_eoc();
        e_drdy = (m_cyc == m_drdy_at);
        if (e_drdy) m_do = m_drdy_data;
        check_eq("eoc",     32'(eoc_out),     32'(e_eoc));
        check_eq("eos",     32'(eos_out),     32'(e_eoc && (((m_cyc / P) % 4) == 3)));
        check_eq("busy",    32'(busy_out),    32'(!rs && !e_eoc));
        check_eq("channel", 32'(channel_out), 32'(exp_chan()));
        check_eq("drdy",    32'(drdy_out),    32'(e_drdy));
        check_eq("do",      32'(do_out),      32'(m_do));
        obs_eoc  = eoc_out;
        obs_chan = channel_out;
        if (drdy_out === 1'b1) drdy_log.push_back(do_out);
        if (rs) begin
            model_reset();
        end else begin
            if (d_en && !(m_drdy_at > m_cyc)) begin
                m_drdy_at   = m_cyc + LAT;
                m_drdy_data = d_we ? 16'h0000 : mapped(a);
            end
            if ((m_cyc % P) == CC - 1) model_capture((m_cyc / P) % 4, stage[(m_cyc / P) % 4]);
            m_cyc++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, 1'b0, 7'h00, 16'h0);
    endtask

    task automatic reader_loop(input int n, input bit only_ch0);
        bit e;
        for (int i = 0; i < n; i++) begin
            e = exp_eoc() && (!only_ch0 || exp_chan() == 5'h13);
            run_cycle(1'b0, e, 1'b0, {2'b00, exp_chan()}, 16'h0);
        end
    endtask

    initial begin
        int          hold;
        logic        rs, d_en, d_we;
        logic [6:0]  a;
        logic [15:0] w;

        model_reset();
        for (int i = 0; i < 4; i++) stage[i] = '0;

        // Reset state, then sequencing with the reader loop attached
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 1'b0, 7'h00, 16'h0);
        stage[0] = 12'h111; stage[1] = 12'h222; stage[2] = 12'h333; stage[3] = 12'h444;
        drdy_log.delete();
        reader_loop(42, 1'b0);
        check_eq("reader_count", 32'(drdy_log.size()), 32'd8);
`ifndef XADC_DRP_AVG_EN
        if (drdy_log.size() >= 4) begin
            check_eq("reader_0", 32'(drdy_log[0]), 32'h1110);
            check_eq("reader_1", 32'(drdy_log[1]), 32'h2220);
            check_eq("reader_2", 32'(drdy_log[2]), 32'h3330);
            check_eq("reader_3", 32'(drdy_log[3]), 32'h4440);
        end
`endif

        // Collision: second den while the first is pending is dropped
        idle(3);
        drdy_log.delete();
        run_cycle(1'b0, 1'b1, 1'b0, 7'h13, 16'h0);
        run_cycle(1'b0, 1'b1, 1'b0, 7'h1A, 16'h0);
        idle(4);
        check_eq("collide_count", 32'(drdy_log.size()), 32'd1);
`ifndef XADC_DRP_AVG_EN
        if (drdy_log.size() >= 1) check_eq("collide_data", 32'(drdy_log[0]), 32'h1110);
`endif

        // Unmapped read, write, read-back
        drdy_log.delete();
        run_cycle(1'b0, 1'b1, 1'b0, 7'h00, 16'h0);   idle(3);
        run_cycle(1'b0, 1'b1, 1'b1, 7'h13, 16'hFFFF); idle(3);
        run_cycle(1'b0, 1'b1, 1'b0, 7'h13, 16'h0);   idle(3);
        check_eq("acc_count", 32'(drdy_log.size()), 32'd3);
        if (drdy_log.size() >= 3) begin
            check_eq("unmapped_data", 32'(drdy_log[0]), 32'h0000);
            check_eq("write_data",    32'(drdy_log[1]), 32'h0000);
`ifndef XADC_DRP_AVG_EN
            check_eq("readback_data", 32'(drdy_log[2]), 32'h1110);
`endif
        end

        // Reset mid-read
        drdy_log.delete();
        run_cycle(1'b0, 1'b1, 1'b0, 7'h1A, 16'h0);
        run_cycle(1'b1, 1'b0, 1'b0, 7'h00, 16'h0);
        run_cycle(1'b1, 1'b0, 1'b0, 7'h00, 16'h0);
        idle(CC + 1);
        check_eq("rst_first_eoc",  32'(obs_eoc),  32'd1);
        check_eq("rst_first_chan", 32'(obs_chan), 32'h13);
        idle(3);
        check_eq("rst_no_drdy", 32'(drdy_log.size()), 32'd0);

        // Randomized traffic with occasional resets
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 4; k++) stage[k] = 12'($urandom);
            if (hold == 0 && $urandom_range(0, 299) == 0) hold = 2;
            rs = (hold > 0);
            if (hold > 0) hold--;
            d_en = ($urandom_range(0, 2) == 0);
            d_we = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0) a = {2'b00, chan_addr(int'($urandom_range(0, 3)))};
            else a = 7'($urandom);
            w = 16'($urandom);
            run_cycle(rs, d_en, d_we, a, w);
        end

`ifdef XADC_DRP_AVG_EN
        // Averaging ramp on a constant input
        for (int i = 0; i < 4; i++) stage[i] = '0;
        stage[0] = 12'h800;
        run_cycle(1'b1, 1'b0, 1'b0, 7'h00, 16'h0);
        run_cycle(1'b1, 1'b0, 1'b0, 7'h00, 16'h0);
        drdy_log.delete();
        reader_loop(4 * P * 4 + P + 3, 1'b1);
        check_eq("avg_count", 32'(drdy_log.size()), 32'd5);
        if (drdy_log.size() >= 5) begin
            check_eq("avg_0", 32'(drdy_log[0]), 32'h2000);
            check_eq("avg_1", 32'(drdy_log[1]), 32'h4000);
            check_eq("avg_2", 32'(drdy_log[2]), 32'h6000);
            check_eq("avg_3", 32'(drdy_log[3]), 32'h8000);
            check_eq("avg_4", 32'(drdy_log[4]), 32'h8000);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
